// File: rtl/trace_cmd_pkg.sv
// Shared constants and parser state type for the trace command controller.
package trace_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] ACK        = 8'h5A;
    localparam logic [7:0] NAK        = 8'hEE;
    localparam logic [7:0] CMD_WIDTH  = 8'h01;
    localparam logic [7:0] CMD_EN     = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;

    typedef enum logic [2:0] {
        P_IDLE,
        P_CMD,
        P_ARG,
        P_SUM,
        P_EXEC
    } parser_state_t;

    // Only 1, 2 and 4 are legal trace bus widths.
    function automatic logic width_ok(input logic [7:0] arg);
        return (arg == 8'd1) || (arg == 8'd2) || (arg == 8'd4);
    endfunction

endpackage

// File: rtl/tx_arbiter.sv
// Shares the UART transmitter between command replies and the trace stream.
// Replies sit in a two-byte buffer and always win a free send slot; a slot
// is withheld for one cycle after each send because uart_free lags by a cycle.
module tx_arbiter (
    input  logic       clkOut,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_b0,
    input  logic [7:0] push_b1,
    output logic       busy,
    input  logic       trace_en,
    input  logic       trc_valid,
    input  logic [7:0] trc_data,
    output logic       trc_ready,
    input  logic       uart_free,
    output logic       uart_send,
    output logic [7:0] uart_byte
);

    logic [7:0] buf0;
    logic [7:0] buf1;
    logic [1:0] pending;
    logic       slot;
    logic       take_reply;
    logic       take_trace;

    assign slot       = uart_free && !uart_send;
    assign take_reply = slot && (pending != 2'd0);
    assign take_trace = slot && (pending == 2'd0) && trace_en && trc_valid && !rst;
    assign trc_ready  = take_trace;
    assign busy       = (pending != 2'd0);

    // Register the send decision and manage the reply buffer occupancy.
    always_ff @(posedge clkOut) begin
        if (rst) begin
            pending   <= 2'd0;
            buf0      <= 8'd0;
            buf1      <= 8'd0;
            uart_send <= 1'b0;
            uart_byte <= 8'd0;
        end else begin
            uart_send <= take_reply || take_trace;
            if (take_reply) begin
                uart_byte <= (pending == 2'd2) ? buf0 : buf1;
                pending   <= pending - 2'd1;
            end else begin
                if (take_trace) begin
                    uart_byte <= trc_data;
                end
                if (push && (pending == 2'd0)) begin
                    pending <= 2'd2;
                    buf0    <= push_b0;
                    buf1    <= push_b1;
                end
            end
        end
    end

endmodule

// File: rtl/trace_cmd_ctrl.sv
// Host command parser for the trace bridge: decodes A5/CMD/ARG/SUM frames,
// owns the trace width and enable registers, and queues replies for the
// shared UART transmitter.
module trace_cmd_ctrl #(
    parameter int         TIMEOUT     = 480000,
    parameter logic [2:0] RESET_WIDTH = 3'd4
) (
    input  logic       clkOut,
    input  logic       rst,
    input  logic       rx_strobe,
    input  logic [7:0] rx_byte,
    input  logic       rx_err,
    input  logic       trc_valid,
    input  logic [7:0] trc_data,
    output logic       trc_ready,
    input  logic       uart_free,
    output logic       uart_send,
    output logic [7:0] uart_byte,
    input  logic       sync,
    input  logic       ovf,
    output logic [2:0] cfg_width,
    output logic       trace_en
);

    import trace_cmd_pkg::*;

    localparam int TW = $clog2(TIMEOUT);

    parser_state_t state;
    parser_state_t state_next;
    logic [7:0]    cmd_r;
    logic [7:0]    arg_r;
    logic [7:0]    sum_r;
    logic [TW-1:0] timer;
    logic          waiting;
    logic          timed_out;
    logic          exec_ok;
    logic          width_we;
    logic          en_we;
    logic [7:0]    reply_b0;
    logic [7:0]    reply_b1;
    logic [7:0]    status;
    logic          reply_busy;

    assign waiting   = (state == P_CMD) || (state == P_ARG) || (state == P_SUM);
    assign timed_out = waiting && (timer == TW'(TIMEOUT - 1));
    assign exec_ok   = (state == P_EXEC) && !rx_err;
    assign status    = {sync, ovf, 2'b00, trace_en, cfg_width};

    // Parser next-state: framing errors and inter-byte timeouts abort to idle.
    always_comb begin
        state_next = state;
        if (rx_err || timed_out) begin
            state_next = P_IDLE;
        end else begin
            case (state)
                P_IDLE:  if (rx_strobe && (rx_byte == SYNC_BYTE)) state_next = P_CMD;
                P_CMD:   if (rx_strobe) state_next = P_ARG;
                P_ARG:   if (rx_strobe) state_next = P_SUM;
                P_SUM:   if (rx_strobe) state_next = P_EXEC;
                P_EXEC:  state_next = P_IDLE;
                default: state_next = P_IDLE;
            endcase
        end
    end

    // Decode the latched frame into a reply and config write enables.
    always_comb begin
        reply_b0 = NAK;
        reply_b1 = cmd_r;
        width_we = 1'b0;
        en_we    = 1'b0;
        if (sum_r == (cmd_r ^ arg_r)) begin
            case (cmd_r)
                CMD_WIDTH: begin
                    if (width_ok(arg_r)) begin
                        reply_b0 = ACK;
                        width_we = 1'b1;
                    end
                end
                CMD_EN: begin
                    reply_b0 = ACK;
                    en_we    = 1'b1;
                end
                CMD_STATUS: begin
                    reply_b0 = ACK;
                    reply_b1 = status;
                end
                default: begin
                    reply_b0 = NAK;
                end
            endcase
        end
    end

    // Parser state register and inter-byte timeout counter.
    always_ff @(posedge clkOut) begin
        if (rst) begin
            state <= P_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            if (waiting && !rx_strobe && !rx_err && !timed_out) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
        end
    end

    // Latch frame bytes as they arrive; an aborting cycle drops its byte.
    always_ff @(posedge clkOut) begin
        if (rst) begin
            cmd_r <= 8'd0;
            arg_r <= 8'd0;
            sum_r <= 8'd0;
        end else if (rx_strobe && !rx_err && !timed_out) begin
            case (state)
                P_CMD:   cmd_r <= rx_byte;
                P_ARG:   arg_r <= rx_byte;
                P_SUM:   sum_r <= rx_byte;
                default: ;
            endcase
        end
    end

    // Config registers change on the edge leaving the execute state.
    always_ff @(posedge clkOut) begin
        if (rst) begin
            cfg_width <= RESET_WIDTH;
            trace_en  <= 1'b1;
        end else if (exec_ok) begin
            if (width_we) cfg_width <= arg_r[2:0];
            if (en_we)    trace_en  <= arg_r[0];
        end
    end

    tx_arbiter u_tx_arbiter (
        .clkOut    (clkOut),
        .rst       (rst),
        .push      (exec_ok),
        .push_b0   (reply_b0),
        .push_b1   (reply_b1),
        .busy      (reply_busy),
        .trace_en  (trace_en),
        .trc_valid (trc_valid),
        .trc_data  (trc_data),
        .trc_ready (trc_ready),
        .uart_free (uart_free),
        .uart_send (uart_send),
        .uart_byte (uart_byte)
    );

    // A frame that executes while a reply is still queued loses its reply.
    logic unused_busy;
    assign unused_busy = reply_busy;

endmodule
